nn_stream_sink: RTL and testbench

- Consumer at the far end of the network's 8-bit result stream (`dout`-style byte-per-cycle output).
- Accepts samples on a valid-qualified input and counts them into fixed-length frames.
- Buffers samples in a small FIFO with a last-of-frame tag and re-emits them on a ready/valid master interface for downstream logging or transfer.
- Optionally computes a per-frame argmax (winning class index and value).

---
 rtl/nn_stream_sink.sv | 165 ++++++++++++++++
 tb/tb_nn_stream_sink.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_stream_sink.sv
// Result-stream sink: counts samples into frames and buffers {last, sample} in a FIFO
// for a ready/valid master. Define NN_SINK_ARGMAX_EN to add the per-frame argmax.
module nn_stream_sink #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FRAME_LEN  = 784,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              overflow,
  output logic [IDX_W-1:0]  class_idx,
  output logic [DATA_W-1:0] class_max,
  output logic              class_valid
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              overflow_q, overflow_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W:0]   mem_q [FIFO_DEPTH];
  logic [DATA_W:0]   head;
  logic              is_last, full, push, pop, drop;

  assign is_last = (idx_q == IDX_W'(FRAME_LEN - 1));
  assign full    = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
  assign m_valid = (count_q != '0);
  assign pop     = m_valid && m_ready;
  // A full FIFO still takes a sample when the head leaves in the same cycle.
  assign push    = din_valid && (!full || pop);
  assign drop    = din_valid && full && !pop;

  assign head   = mem_q[rd_ptr_q];
  assign m_data = m_valid ? head[DATA_W-1:0] : '0;
  assign m_last = m_valid ? head[DATA_W] : 1'b0;

  always_comb begin
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (clr) begin
      idx_d       = '0;
      frame_cnt_d = '0;
      overflow_d  = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
    end else begin
      // Framing follows the source, so dropped samples still advance the index.
      if (din_valid) begin
        if (is_last) begin
          idx_d       = '0;
          frame_cnt_d = frame_cnt_q + 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      if (drop) overflow_d = 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q       <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: outputs are gated by m_valid.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem_q[wr_ptr_q] <= {is_last, din};
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign overflow  = overflow_q;

`ifdef NN_SINK_ARGMAX_EN
  logic signed [DATA_W-1:0] run_max_q, cand_max;
  logic [IDX_W-1:0]         run_idx_q, cand_idx;
  logic [DATA_W-1:0]        class_max_q;
  logic [IDX_W-1:0]         class_idx_q;
  logic                     class_valid_q;

  // First sample of a frame loads unconditionally; strict > keeps the lowest index on ties.
  always_comb begin
    cand_max = run_max_q;
    cand_idx = run_idx_q;
    if ((idx_q == '0) || ($signed(din) > run_max_q)) begin
      cand_max = $signed(din);
      cand_idx = idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_max_q     <= '0;
      run_idx_q     <= '0;
      class_max_q   <= '0;
      class_idx_q   <= '0;
      class_valid_q <= 1'b0;
    end else if (clr) begin
      run_max_q     <= '0;
      run_idx_q     <= '0;
      class_max_q   <= '0;
      class_idx_q   <= '0;
      class_valid_q <= 1'b0;
    end else begin
      class_valid_q <= 1'b0;
      if (din_valid) begin
        run_max_q <= cand_max;
        run_idx_q <= cand_idx;
        if (is_last) begin
          class_max_q   <= cand_max;
          class_idx_q   <= cand_idx;
          class_valid_q <= 1'b1;
        end
      end
    end
  end

  assign class_idx   = class_idx_q;
  assign class_max   = class_max_q;
  assign class_valid = class_valid_q;
`else
  assign class_idx   = '0;
  assign class_max   = '0;
  assign class_valid = 1'b0;
`endif

endmodule

// File: tb/tb_nn_stream_sink.sv
// Randomised + directed bench for nn_stream_sink with a queue-based reference model and
// a negedge monitor acting as scoreboard.
module tb_nn_stream_sink;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FRAME_LEN  = 4;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned IDX_W      = $clog2(FRAME_LEN);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clr = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [CNT_W-1:0]  frame_cnt;
  logic              overflow;
  logic [IDX_W-1:0]  class_idx;
  logic [DATA_W-1:0] class_max;
  logic              class_valid;

  int checks = 0;
  int errors = 0;

  nn_stream_sink #(
    .DATA_W    (DATA_W),
    .FRAME_LEN (FRAME_LEN),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .din        (din),
    .din_valid  (din_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .frame_cnt  (frame_cnt),
    .overflow   (overflow),
    .class_idx  (class_idx),
    .class_max  (class_max),
    .class_valid(class_valid)
  );

  always #5 clk = ~clk;

  // Reference model state (represents the DUT after the most recent edge).
  logic [DATA_W:0]          exp_q [$];
  logic signed [DATA_W-1:0] frame_s [$];
  int                       m_occ = 0;
  int                       m_idx = 0;
  logic                     m_ovf = 1'b0;
  logic [CNT_W-1:0]         m_frames = '0;
  logic [IDX_W-1:0]         m_cidx = '0;
  logic [DATA_W-1:0]        m_cmax = '0;
  logic                     m_cv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    frame_s.delete();
    m_occ    = 0;
    m_idx    = 0;
    m_ovf    = 1'b0;
    m_frames = '0;
    m_cidx   = '0;
    m_cmax   = '0;
    m_cv     = 1'b0;
  endfunction

  // Apply the inputs that were present at this edge to the model.
  always @(posedge clk) begin : model
    bit pop, last;
    logic signed [DATA_W-1:0] best;
    int bi;
    #1;
    if (!rst || clr) begin
      model_reset();
    end else begin
      pop  = (m_occ != 0) && m_ready;
      m_cv = 1'b0;
      if (din_valid) begin
        last = (m_idx == FRAME_LEN - 1);
        if (m_occ < FIFO_DEPTH || pop) begin
          exp_q.push_back({last, din});
          m_occ++;
        end else begin
          m_ovf = 1'b1;
        end
        frame_s.push_back($signed(din));
        if (last) begin
          best = frame_s[0];
          bi   = 0;
          for (int i = 1; i < frame_s.size(); i++) begin
            if (frame_s[i] > best) begin
              best = frame_s[i];
              bi   = i;
            end
          end
          m_cmax = best;
          m_cidx = IDX_W'(bi);
          m_cv   = 1'b1;
          m_frames++;
          m_idx = 0;
          frame_s.delete();
        end else begin
          m_idx++;
        end
      end
      if (pop) m_occ--;
    end
  end

  // Scoreboard monitor: compares the head whenever the DUT presents it.
  always @(negedge clk) begin
    logic [DATA_W:0] e;
    chk("m_valid", 32'(m_valid), 32'(m_occ != 0));
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard got data %0h want nothing at %0t", m_data, $time);
      end else begin
        e = exp_q[0];
        chk("m_data", 32'(m_data), 32'(e[DATA_W-1:0]));
        chk("m_last", 32'(m_last), 32'(e[DATA_W]));
        if (m_ready) void'(exp_q.pop_front());
      end
    end
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
`ifdef NN_SINK_ARGMAX_EN
    chk("class_valid", 32'(class_valid), 32'(m_cv));
    chk("class_idx", 32'(class_idx), 32'(m_cidx));
    chk("class_max", 32'(class_max), 32'(m_cmax));
`else
    chk("class_valid", 32'(class_valid), 32'd0);
    chk("class_idx", 32'(class_idx), 32'd0);
    chk("class_max", 32'(class_max), 32'd0);
`endif
  end

  task automatic drive(input bit c, input bit v, input logic [DATA_W-1:0] d, input bit r);
    @(posedge clk);
    #2;
    clr       = c;
    din_valid = v;
    din       = d;
    m_ready   = r;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    int mode;
    logic [DATA_W-1:0] f1 [4];
    logic [DATA_W-1:0] f2 [4];
    f1[0] = 8'hFD; f1[1] = 8'hFD; f1[2] = 8'hF9; f1[3] = 8'hFD;
    f2[0] = 8'h01; f2[1] = 8'h02; f2[2] = 8'h02; f2[3] = 8'h00;

    // Reset held for 3 cycles; monitor checks idle outputs throughout.
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Single frame with argmax winner at index 1.
    drive(0, 1, 8'h05, 1);
    drive(0, 1, 8'h7F, 1);
    drive(0, 1, 8'h80, 1);
    drive(0, 1, 8'h10, 1);
    drive(0, 0, 8'h00, 1);
    @(negedge clk);
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd1);
`ifdef NN_SINK_ARGMAX_EN
    chk("t2_class_valid", 32'(class_valid), 32'd1);
    chk("t2_class_idx", 32'(class_idx), 32'd1);
    chk("t2_class_max", 32'(class_max), 32'h7F);
`endif
    drain(4);

    // Overflow under backpressure, then in-order drain.
    drive(1, 0, 8'h00, 0);
    for (int i = 0; i < 18; i++) drive(0, 1, DATA_W'(i), 0);
    drive(0, 0, 8'h00, 0);
    @(negedge clk);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_full_valid", 32'(m_valid), 32'd1);
    drain(20);
    @(negedge clk);
    chk("t3_drained", 32'(m_valid), 32'd0);

    // Full FIFO with simultaneous push and pop never drops.
    drive(1, 0, 8'h00, 0);
    for (int i = 0; i < 16; i++) drive(0, 1, DATA_W'(i + 32), 0);
    for (int i = 0; i < 4; i++) drive(0, 1, DATA_W'(i + 64), 1);
    drive(0, 0, 8'h00, 0);
    @(negedge clk);
    chk("t4_overflow", 32'(overflow), 32'd0);
    chk("t4_valid", 32'(m_valid), 32'd1);
    drain(20);

    // Argmax tie keeps lowest index; second frame exercises wrap.
    drive(1, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) drive(0, 1, f1[i], 1);
    drive(0, 0, 8'h00, 1);
    @(negedge clk);
`ifdef NN_SINK_ARGMAX_EN
    chk("t5_idx_a", 32'(class_idx), 32'd0);
    chk("t5_max_a", 32'(class_max), 32'hFD);
`endif
    for (int i = 0; i < 4; i++) drive(0, 1, f2[i], 1);
    drive(0, 0, 8'h00, 1);
    @(negedge clk);
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd2);
`ifdef NN_SINK_ARGMAX_EN
    chk("t5_idx_b", 32'(class_idx), 32'd1);
    chk("t5_max_b", 32'(class_max), 32'h02);
`endif
    drain(4);

    // clr mid-frame restarts framing.
    drive(1, 0, 8'h00, 0);
    drive(0, 1, 8'h11, 0);
    drive(0, 1, 8'h22, 0);
    drive(1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, DATA_W'(8'hA0 + i), 0);
    drive(0, 0, 8'h00, 0);
    @(negedge clk);
    chk("t6_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t6_overflow", 32'(overflow), 32'd0);
    drain(10);

    // Random traffic with phases of heavy and light backpressure.
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) mode = $urandom_range(0, 2);
      drive(($urandom % 250) == 0, ($urandom % 4) != 0, DATA_W'($urandom),
            (mode == 0) ? 1'b1 : (mode == 1) ? (($urandom % 2) == 0) : (($urandom % 8) == 0));
    end
    drain(40);
    @(negedge clk);
    chk("final_empty", 32'(m_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
